// File: rtl/serial_pattern_gen_if.sv
// Handshake bundle for the serial pattern transmitter: control inputs
// (start / repeat_count / abort) and the registered serial stream outputs.
interface serial_pattern_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] repeat_count;
  logic             abort;
  logic             data;
  logic             valid;
  logic             busy;
  logic             done;

  // Stimulus side: drives the controls, observes the stream.
  modport master (
    output start,
    output repeat_count,
    output abort,
    input  data,
    input  valid,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  start,
    input  repeat_count,
    input  abort,
    output data,
    output valid,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// Moore serial bit-pattern transmitter. Sends PATTERN MSB first, one bit per
// clock, repeat_count+1 times, with GAP zero bits (still marked valid)
// between repetitions. Every output is a flop loaded with the value that
// belongs to the state being entered, so no input reaches an output
// combinationally.
module serial_pattern_gen #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 4,
  parameter int             GAP     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_pattern_gen_if.slave   bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // The gap counter is kept at one bit when GAP is 0; it is never loaded then.
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] reps_left_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] idx_dec_s;
  logic             pat_next_s;

  // Pattern bit that will be on the line after bit_idx steps down by one.
  always_comb begin
    idx_dec_s  = bit_idx_q - IDX_ONE;
    pat_next_s = PATTERN[idx_dec_s];
  end

  // Controller and datapath: next state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      reps_left_q <= '0;
      gap_cnt_q   <= '0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // abort is irrelevant here, so start always wins in IDLE.
            state_q     <= ST_SHIFT;
            reps_left_q <= bus.repeat_count;
            bit_idx_q   <= IDX_MSB;
            data_q      <= PATTERN[PAT_W-1];
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (bit_idx_q != '0) begin
            bit_idx_q <= idx_dec_s;
            data_q    <= pat_next_s;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end else if (reps_left_q == '0) begin
            state_q <= ST_DONE;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (GAP == 0) begin
            // Next repetition starts immediately: MSB follows with no bubble.
            reps_left_q <= reps_left_q - REP_ONE;
            bit_idx_q   <= IDX_MSB;
            data_q      <= PATTERN[PAT_W-1];
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end else begin
            state_q     <= ST_GAP;
            reps_left_q <= reps_left_q - REP_ONE;
            gap_cnt_q   <= GAP_LOAD;
            data_q      <= 1'b0;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end

        ST_GAP: begin
          done_q <= 1'b0;
          if (bus.abort) begin
            state_q <= ST_IDLE;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
            data_q    <= 1'b0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= ST_SHIFT;
            bit_idx_q <= IDX_MSB;
            data_q    <= PATTERN[PAT_W-1];
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        ST_DONE: begin
          // One-cycle pulse; start and abort are both ignored here.
          state_q <= ST_IDLE;
          data_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          data_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
